uart_tx_fifo_cfg: RTL and testbench

//  Next-gen UART transmitter: buffered and runtime-configurable. A FIFO decouples the producer; an

---
 rtl/uart_tx_fifo_cfg_if.sv | 21 ++
 rtl/uart_tx_fifo_cfg.sv | 206 ++++++++++++++++++++
 tb/tb_uart_tx_fifo_cfg.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_cfg_if.sv
// Producer-side handshake bundle for the buffered UART transmitter.
// The master offers P_DATA with Data_Valid, and the slave accepts it while Data_Ready is high.
interface uart_tx_fifo_cfg_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Data_Ready;

    modport master (
        output P_DATA,
        output Data_Valid,
        input  Data_Ready
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        output Data_Ready
    );
endinterface

// File: rtl/uart_tx_fifo_cfg.sv
// Buffered UART transmitter with a runtime-configurable frame format.
// An input FIFO feeds a frame FSM that uses a per-frame baud divider and sends data LSB first.
module uart_tx_fifo_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    uart_tx_fifo_cfg_if.slave            bus,
    input  logic [3:0]                   DATA_LEN,
    input  logic                         PAR_EN,
    input  logic                         PAR_TYP,
    input  logic                         STOP_2,
    input  logic [DIV_W-1:0]             BAUD_DIV,
    output logic                         TX_OUT,
    output logic                         BUSY,
    output logic [$clog2(FIFO_DEPTH):0]  FIFO_LVL
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  LEN_MAX  = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP1,
        S_STOP2
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [AW:0]           lvl_q, lvl_d;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] head, masked;
    logic [3:0]            len_eff;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      baud_q, baud_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [3:0]            bit_q, bit_d;
    logic [3:0]            len_q, len_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic                  par_q, par_d;
    logic                  pen_q, pen_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  tick_end, fin, load;

    assign bus.Data_Ready = !RST && (lvl_q != LVL_FULL);
    assign push     = bus.Data_Valid && bus.Data_Ready;
    assign head     = mem_q[rptr_q];
    assign TX_OUT   = tx_q;
    assign BUSY     = busy_q;
    assign FIFO_LVL = lvl_q;

    always_comb begin
        lvl_d = lvl_q;
        if (push && !pop) begin
            lvl_d = lvl_q + (AW+1)'(1);
        end else if (!push && pop) begin
            lvl_d = lvl_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q <= '0;
            rptr_q <= '0;
            lvl_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= bus.P_DATA;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            lvl_q <= lvl_d;
        end
    end

    // Out-of-range lengths fall back to the full word; untransmitted bits are zeroed
    always_comb begin
        len_eff = LEN_MAX;
        if (DATA_LEN >= 4'd5 && DATA_LEN <= LEN_MAX) begin
            len_eff = DATA_LEN;
        end
        masked = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            masked[i] = head[i] & (i < int'(len_eff));
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        div_d    = div_q;
        bit_d    = bit_q;
        len_d    = len_q;
        sh_d     = sh_q;
        par_d    = par_q;
        pen_d    = pen_q;
        stop2_d  = stop2_q;
        pop      = 1'b0;
        fin      = 1'b0;
        load     = 1'b0;
        tick_end = (baud_q == div_q);

        if (state_q != S_IDLE) begin
            baud_d = tick_end ? '0 : baud_q + DIV_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                load = (lvl_q != '0);
            end
            S_START: begin
                if (tick_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick_end) begin
                    if (bit_q == len_q - 4'd1) begin
                        bit_d   = '0;
                        state_d = pen_q ? S_PAR : S_STOP1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        sh_d  = sh_q >> 1;
                    end
                end
            end
            S_PAR: begin
                if (tick_end) state_d = S_STOP1;
            end
            S_STOP1: begin
                if (tick_end) begin
                    if (stop2_q) state_d = S_STOP2;
                    else         fin     = 1'b1;
                end
            end
            S_STOP2: begin
                if (tick_end) fin = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Back-to-back frames restart directly from the last stop bit
        if (fin) begin
            if (lvl_q != '0) load    = 1'b1;
            else             state_d = S_IDLE;
        end

        if (load) begin
            pop     = 1'b1;
            state_d = S_START;
            baud_d  = '0;
            bit_d   = '0;
            sh_d    = masked;
            par_d   = (^masked) ^ PAR_TYP;
            len_d   = len_eff;
            pen_d   = PAR_EN;
            stop2_d = STOP_2;
            div_d   = BAUD_DIV;
        end

        tx_d = 1'b1;
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sh_d[0];
            S_PAR:   tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            len_q   <= LEN_MAX;
            sh_q    <= '0;
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            pen_q   <= pen_d;
            stop2_q <= stop2_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Directed bench for uart_tx_fifo_cfg: a queue holds the expected per-cycle line level,
// which a small frame model builds from the configuration in use.
module tb_uart_tx_fifo_cfg;
    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  DATA_LEN;
    logic        PAR_EN;
    logic        PAR_TYP;
    logic        STOP_2;
    logic [15:0] BAUD_DIV;
    logic        TX_OUT;
    logic        BUSY;
    logic [2:0]  FIFO_LVL;

    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];

    uart_tx_fifo_cfg_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_fifo_cfg #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(4),
        .DIV_W(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus),
        .DATA_LEN(DATA_LEN),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .STOP_2(STOP_2),
        .BAUD_DIV(BAUD_DIV),
        .TX_OUT(TX_OUT),
        .BUSY(BUSY),
        .FIFO_LVL(FIFO_LVL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; while a frame is expected, check the line and BUSY
    task automatic tick();
        logic e;
        @(posedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("tx_bit", {31'd0, TX_OUT}, {31'd0, e});
            chk("busy_in_frame", {31'd0, BUSY}, 32'd1);
        end
    endtask

    task automatic add_bit(input logic b, input int hold);
        for (int k = 0; k < hold; k++) exp_q.push_back(b);
    endtask

    task automatic add_frame(input logic [7:0] d, input logic [3:0] len,
                             input logic pe, input logic pt, input logic s2,
                             input logic [15:0] div);
        int   l;
        int   h;
        logic p;
        l = (len < 4'd5 || len > 4'd8) ? 8 : int'(len);
        h = int'(div) + 1;
        p = pt;
        add_bit(1'b0, h);
        for (int i = 0; i < l; i++) begin
            add_bit(d[i], h);
            p = p ^ d[i];
        end
        if (pe) add_bit(p, h);
        add_bit(1'b1, h);
        if (s2) add_bit(1'b1, h);
    endtask

    task automatic drain_and_idle(input string tag);
        while (exp_q.size() != 0) tick();
        tick();
        chk({tag, "_idle_tx"}, {31'd0, TX_OUT}, 32'd1);
        chk({tag, "_idle_busy"}, {31'd0, BUSY}, 32'd0);
        chk({tag, "_idle_lvl"}, {29'd0, FIFO_LVL}, 32'd0);
    endtask

    task automatic send_one(input string tag, input logic [7:0] d);
        bus.P_DATA     = d;
        bus.Data_Valid = 1'b1;
        tick();
        bus.Data_Valid = 1'b0;
        chk({tag, "_lvl_after_push"}, {29'd0, FIFO_LVL}, 32'd1);
        add_frame(d, DATA_LEN, PAR_EN, PAR_TYP, STOP_2, BAUD_DIV);
        drain_and_idle(tag);
    endtask

    initial begin
        RST            = 1'b1;
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        DATA_LEN       = 4'd8;
        PAR_EN         = 1'b0;
        PAR_TYP        = 1'b0;
        STOP_2         = 1'b0;
        BAUD_DIV       = 16'd0;

        tick();
        tick();
        chk("rst_tx", {31'd0, TX_OUT}, 32'd1);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_lvl", {29'd0, FIFO_LVL}, 32'd0);
        chk("rst_ready", {31'd0, bus.Data_Ready}, 32'd0);
        RST = 1'b0;
        tick();
        chk("ready_after_rst", {31'd0, bus.Data_Ready}, 32'd1);

        // 8N1 at one cycle per bit
        send_one("t1_a5", 8'hA5);

        // Parity even then odd, four cycles per bit
        PAR_EN   = 1'b1;
        PAR_TYP  = 1'b0;
        BAUD_DIV = 16'd3;
        send_one("t2_even", 8'h03);
        PAR_TYP = 1'b1;
        send_one("t2_odd", 8'h03);

        // Five data bits, two stop bits, upper bits dropped
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        BAUD_DIV = 16'd0;
        DATA_LEN = 4'd5;
        STOP_2   = 1'b1;
        send_one("t3_len5", 8'hFF);

        // Too-short length is clamped to the full word
        DATA_LEN = 4'd3;
        STOP_2   = 1'b0;
        PAR_EN   = 1'b1;
        send_one("t3_clamp", 8'h81);

        // Fill the FIFO while a frame is running
        DATA_LEN = 4'd8;
        PAR_EN   = 1'b0;
        bus.Data_Valid = 1'b1;
        bus.P_DATA     = 8'h11;
        tick();
        chk("t4_lvl_e0", {29'd0, FIFO_LVL}, 32'd1);
        add_frame(8'h11, 4'd8, 1'b0, 1'b0, 1'b0, 16'd0);
        add_frame(8'h22, 4'd8, 1'b0, 1'b0, 1'b0, 16'd0);
        add_frame(8'h33, 4'd8, 1'b0, 1'b0, 1'b0, 16'd0);
        add_frame(8'h44, 4'd8, 1'b0, 1'b0, 1'b0, 16'd0);
        add_frame(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, 16'd0);
        bus.P_DATA = 8'h22;
        tick();
        chk("t4_lvl_e1", {29'd0, FIFO_LVL}, 32'd1);
        bus.P_DATA = 8'h33;
        tick();
        chk("t4_lvl_e2", {29'd0, FIFO_LVL}, 32'd2);
        bus.P_DATA = 8'h44;
        tick();
        chk("t4_lvl_e3", {29'd0, FIFO_LVL}, 32'd3);
        chk("t4_ready_lvl3", {31'd0, bus.Data_Ready}, 32'd1);
        bus.P_DATA = 8'h55;
        tick();
        chk("t4_lvl_full", {29'd0, FIFO_LVL}, 32'd4);
        chk("t4_ready_full", {31'd0, bus.Data_Ready}, 32'd0);
        bus.P_DATA = 8'h66;
        tick();
        tick();
        chk("t4_lvl_held", {29'd0, FIFO_LVL}, 32'd4);
        chk("t4_ready_held", {31'd0, bus.Data_Ready}, 32'd0);
        bus.Data_Valid = 1'b0;
        drain_and_idle("t4_burst");

        // Reset in the middle of a data bit with two words queued
        BAUD_DIV = 16'd3;
        bus.Data_Valid = 1'b1;
        bus.P_DATA     = 8'h0F;
        tick();
        bus.P_DATA = 8'hF0;
        tick();
        bus.P_DATA = 8'hAA;
        tick();
        bus.Data_Valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_lvl_pre", {29'd0, FIFO_LVL}, 32'd2);
        chk("t5_busy_pre", {31'd0, BUSY}, 32'd1);
        RST = 1'b1;
        tick();
        chk("t5_rst_tx", {31'd0, TX_OUT}, 32'd1);
        chk("t5_rst_busy", {31'd0, BUSY}, 32'd0);
        chk("t5_rst_lvl", {29'd0, FIFO_LVL}, 32'd0);
        chk("t5_rst_ready", {31'd0, bus.Data_Ready}, 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("t5_quiet_tx", {31'd0, TX_OUT}, 32'd1);
            chk("t5_quiet_busy", {31'd0, BUSY}, 32'd0);
        end

        // New settings applied mid-frame only take effect on the next frame
        BAUD_DIV = 16'd0;
        DATA_LEN = 4'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        bus.Data_Valid = 1'b1;
        bus.P_DATA     = 8'h3C;
        tick();
        bus.Data_Valid = 1'b0;
        add_frame(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 16'd0);
        tick();
        PAR_EN   = 1'b1;
        PAR_TYP  = 1'b1;
        DATA_LEN = 4'd6;
        BAUD_DIV = 16'd1;
        bus.Data_Valid = 1'b1;
        bus.P_DATA     = 8'hC7;
        tick();
        bus.Data_Valid = 1'b0;
        add_frame(8'hC7, 4'd6, 1'b1, 1'b1, 1'b0, 16'd1);
        drain_and_idle("t6_cfg");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
